gmii_udp_pix_rx: RTL

//  Multi-channel successor of the single-stream GMII pixel receiver. Parses

---
 rtl/gmii_udp_pix_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gmii_udp_pix_rx.sv
// GMII RX Ethernet/IPv4/UDP parser that packs payload pixels into channel-tagged FIFO words.
// Define GMII_VLAN_EN to accept 802.1Q-tagged frames; all header offsets then shift by 4.
module gmii_udp_pix_rx #(
  parameter logic [31:0] IPV4_DST    = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] PORT_BASE   = 16'd12345,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned BPP         = 2,
  parameter int unsigned PIX_PER_PKT = 640,
  localparam int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned OUT_W      = CHW + 16 + 8 * BPP
) (
  input  logic             clk125,
  input  logic             sys_rst,
  input  logic             id,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             fifo_full,
  output logic [OUT_W-1:0] datain,
  output logic             recv_en,
  output logic             packet_en,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned PW  = 8 * BPP;
  localparam int unsigned PCW = $clog2(PIX_PER_PKT + 1);
  localparam int unsigned KW  = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DROP} state_t;

  state_t           r_state, w_state_nx;
  logic [6:0]       r_bc;
  logic             r_prev_low;
  logic             r_ok;
  logic             r_vlan;
  logic [7:0]       r_eth_hi;
  logic [15:0]      r_port;
  logic [7:0]       r_b0, r_b1;
  logic [CHW-1:0]   r_ch;
  logic [KW-1:0]    r_k;
  logic [PCW-1:0]   r_pcnt;
  logic [PW-9:0]    r_pix;
  logic             r_recv_en, r_done, r_err;
  logic [OUT_W-1:0] r_datain;
  logic [15:0]      r_drop_cnt;

  logic [6:0]       w_sh;
  logic [15:0]      w_port_off;
  logic             w_at_dec, w_accept, w_pix_last, w_last_pix;
  logic [PW-1:0]    w_pix_nx;
  logic [7:0]       w_ip_lo;

  assign w_sh       = r_vlan ? 7'd4 : 7'd0;
  assign w_port_off = r_port - PORT_BASE;
  assign w_at_dec   = (r_bc == 7'd51 + w_sh);
  assign w_accept   = r_ok && (w_port_off < 16'(NUM_CH));
  assign w_pix_last = (r_k == KW'(BPP - 1));
  assign w_last_pix = (r_pcnt == PCW'(PIX_PER_PKT - 1));
  assign w_pix_nx   = {r_pix, rxd};
  assign w_ip_lo    = IPV4_DST[7:0] + {7'd0, id};

  // Saturating byte counter; only header offsets below 64 matter.
  always_ff @(posedge clk125) begin
    if (sys_rst || !rx_dv) r_bc <= '0;
    else if (r_bc != '1)   r_bc <= r_bc + 7'd1;
  end

  // A frame may only start after rx_dv has been seen low, so a reset mid-frame skips its tail.
  always_ff @(posedge clk125) begin
    if (sys_rst) r_prev_low <= 1'b0;
    else         r_prev_low <= ~rx_dv;
  end

  always_ff @(posedge clk125) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (rx_dv && r_prev_low) w_state_nx = S_HDR;
      S_HDR:   if (!rx_dv) w_state_nx = S_IDLE;
               else if (w_at_dec) w_state_nx = w_accept ? S_PAY : S_DROP;
      S_PAY:   if (!rx_dv) w_state_nx = S_IDLE;
               else if (w_pix_last && w_last_pix) w_state_nx = S_DROP;
      S_DROP:  if (!rx_dv) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      r_ok     <= 1'b0;
      r_vlan   <= 1'b0;
      r_eth_hi <= '0;
      r_port   <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_ch     <= '0;
    end else if (r_state == S_IDLE) begin
      r_ok   <= 1'b1;
      r_vlan <= 1'b0;
    end else if (r_state == S_HDR && rx_dv) begin
      if (r_bc == 7'd20) r_eth_hi <= rxd;
      if (r_bc == 7'd21) begin
`ifdef GMII_VLAN_EN
        if ({r_eth_hi, rxd} == 16'h8100)      r_vlan <= 1'b1;
        else if ({r_eth_hi, rxd} != 16'h0800) r_ok   <= 1'b0;
`else
        if ({r_eth_hi, rxd} != 16'h0800) r_ok <= 1'b0;
`endif
      end
      if (r_vlan && r_bc == 7'd24 && rxd != 8'h08) r_ok <= 1'b0;
      if (r_vlan && r_bc == 7'd25 && rxd != 8'h00) r_ok <= 1'b0;
      if (r_bc == 7'd22 + w_sh && rxd != 8'h45)            r_ok <= 1'b0;
      if (r_bc == 7'd31 + w_sh && rxd != 8'h11)            r_ok <= 1'b0;
      if (r_bc == 7'd38 + w_sh && rxd != IPV4_DST[31:24])  r_ok <= 1'b0;
      if (r_bc == 7'd39 + w_sh && rxd != IPV4_DST[23:16])  r_ok <= 1'b0;
      if (r_bc == 7'd40 + w_sh && rxd != IPV4_DST[15:8])   r_ok <= 1'b0;
      if (r_bc == 7'd41 + w_sh && rxd != w_ip_lo)          r_ok <= 1'b0;
      if (r_bc == 7'd44 + w_sh) r_port[15:8] <= rxd;
      if (r_bc == 7'd45 + w_sh) r_port[7:0]  <= rxd;
      if (r_bc == 7'd50 + w_sh) r_b0 <= rxd;
      if (w_at_dec) begin
        r_b1 <= rxd;
        r_ch <= w_port_off[CHW-1:0];
      end
    end
  end

  // fifo_full is sampled with the pixel's last byte; a dropped word still advances the pixel count.
  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      r_k       <= '0;
      r_pcnt    <= '0;
      r_pix     <= '0;
      r_recv_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_datain  <= '0;
    end else begin
      r_recv_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= (r_state == S_PAY) && !rx_dv;
      if (r_state != S_PAY) begin
        r_k    <= '0;
        r_pcnt <= '0;
      end else if (rx_dv) begin
        r_pix <= w_pix_nx[PW-9:0];
        if (w_pix_last) begin
          r_k    <= '0;
          r_pcnt <= r_pcnt + PCW'(1);
          r_done <= w_last_pix;
          if (!fifo_full) begin
            r_recv_en <= 1'b1;
            r_datain  <= {r_ch, r_b1, r_b0, w_pix_nx};
          end
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk125) begin
    if (sys_rst)
      r_drop_cnt <= '0;
    else if (r_state == S_PAY && rx_dv && w_pix_last && fifo_full && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign datain    = r_datain;
  assign recv_en   = r_recv_en;
  assign packet_en = (r_state == S_PAY);
  assign pkt_done  = r_done;
  assign pkt_err   = r_err;
  assign drop_cnt  = r_drop_cnt;

endmodule
